// File: rtl/csr_bank.sv
// Machine/Supervisor CSR bank with trap entry, mret/sret and privilege tracking.
// Optional mcycle/minstret counters (and their cycle/instret aliases) exist only when CSR_COUNTERS_EN is defined.
module csr_bank #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          csr_addr,
  input  logic                 csr_wr_en,
  input  logic [1:0]           csr_op,
  input  logic                 csr_imm,
  input  logic [4:0]           rs1_field,
  input  logic [DATA_SIZE-1:0] rs1_data,
  input  logic                 trap,
  input  logic                 mret,
  input  logic                 sret,
  input  logic                 retire,
  input  logic [DATA_SIZE-1:0] trap_cause,
  input  logic [DATA_SIZE-1:0] trap_pc,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 csr_addr_invalid,
  output logic [1:0]           privilege_mode,
  output logic [DATA_SIZE-1:0] trap_vector,
  output logic [DATA_SIZE-1:0] mepc_out,
  output logic [DATA_SIZE-1:0] sepc_out
);

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_e;

  localparam logic [11:0] A_SSTATUS  = 12'h100;
  localparam logic [11:0] A_STVEC    = 12'h105;
  localparam logic [11:0] A_SSCRATCH = 12'h140;
  localparam logic [11:0] A_SEPC     = 12'h141;
  localparam logic [11:0] A_SCAUSE   = 12'h142;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
`endif

  // misa: MXL in the top two bits, extensions I, S and U.
  localparam logic [1:0]           MXL        = (DATA_SIZE == 64) ? 2'd2 : 2'd1;
  localparam logic [DATA_SIZE-1:0] MISA_VAL   = {MXL, {(DATA_SIZE-28){1'b0}}, 26'h0140100};
  localparam logic [DATA_SIZE-1:0] ALIGN_MASK = ~DATA_SIZE'(3);

  priv_e                priv_q, priv_d;
  logic                 mie_q, mie_d, mpie_q, mpie_d;
  logic [1:0]           mpp_q, mpp_d;
  logic                 sie_q, sie_d, spie_q, spie_d, spp_q, spp_d;
  logic [DATA_SIZE-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [DATA_SIZE-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [DATA_SIZE-1:0] stvec_q, stvec_d, sscratch_q, sscratch_d;
  logic [DATA_SIZE-1:0] sepc_q, sepc_d, scause_q, scause_d;
`ifdef CSR_COUNTERS_EN
  logic [DATA_SIZE-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic                 unused_retire;
  assign unused_retire = retire;
`endif

  logic [DATA_SIZE-1:0] mstatus_view, sstatus_view;
  logic [DATA_SIZE-1:0] csr_rdata, operand, new_val;
  logic                 implemented, wr_intent, csr_we;
  logic [1:0]           priv_bits;

  assign priv_bits = priv_q;

  always_comb begin
    mstatus_view     = '0;
    mstatus_view[3]  = mie_q;
    mstatus_view[7]  = mpie_q;
    mstatus_view[12:11] = mpp_q;
    sstatus_view     = '0;
    sstatus_view[1]  = sie_q;
    sstatus_view[5]  = spie_q;
    sstatus_view[8]  = spp_q;
  end

  always_comb begin
    csr_rdata   = '0;
    implemented = 1'b1;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus_view;
      A_MISA:     csr_rdata = MISA_VAL;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_SSTATUS:  csr_rdata = sstatus_view;
      A_STVEC:    csr_rdata = stvec_q;
      A_SSCRATCH: csr_rdata = sscratch_q;
      A_SEPC:     csr_rdata = sepc_q;
      A_SCAUSE:   csr_rdata = scause_q;
      A_MHARTID:  csr_rdata = '0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE, A_CYCLE:     csr_rdata = mcycle_q;
      A_MINSTRET, A_INSTRET: csr_rdata = minstret_q;
`endif
      default:    implemented = 1'b0;
    endcase
  end

  // op 00 is not a CSR access encoding, so it never carries write intent.
  assign wr_intent = csr_wr_en && (csr_op != 2'b00) &&
                     ((csr_op == 2'b01) || (rs1_field != 5'd0));

  assign csr_addr_invalid = !implemented ||
                            (priv_bits < csr_addr[9:8]) ||
                            ((csr_addr[11:10] == 2'b11) && wr_intent);

  assign rd_data = csr_addr_invalid ? '0 : csr_rdata;
  assign csr_we  = wr_intent && !csr_addr_invalid;
  assign operand = csr_imm ? DATA_SIZE'(rs1_field) : rs1_data;

  always_comb begin
    case (csr_op)
      2'b10:   new_val = csr_rdata | operand;
      2'b11:   new_val = csr_rdata & ~operand;
      default: new_val = operand;
    endcase
  end

  always_comb begin
    priv_d     = priv_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mpp_d      = mpp_q;
    sie_d      = sie_q;
    spie_d     = spie_q;
    spp_d      = spp_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + DATA_SIZE'(1);
    minstret_d = minstret_q + DATA_SIZE'(retire);
`endif
    // Only the highest-priority event of the cycle takes effect.
    if (trap) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
      mpp_d    = priv_bits;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      priv_d   = PRIV_M;
    end else if (mret) begin
      priv_d = priv_e'(mpp_q);
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = PRIV_U;
    end else if (sret) begin
      priv_d = spp_q ? PRIV_S : PRIV_U;
      sie_d  = spie_q;
      spie_d = 1'b1;
      spp_d  = 1'b0;
    end else if (csr_we) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
          // MPP=10 is a reserved mode; such a write keeps the old field.
          if (new_val[12:11] != 2'b10) mpp_d = new_val[12:11];
        end
        A_SSTATUS: begin
          sie_d  = new_val[1];
          spie_d = new_val[5];
          spp_d  = new_val[8];
        end
        A_MTVEC:    mtvec_d    = new_val & ALIGN_MASK;
        A_MSCRATCH: mscratch_d = new_val;
        A_MEPC:     mepc_d     = new_val & ALIGN_MASK;
        A_MCAUSE:   mcause_d   = new_val;
        A_STVEC:    stvec_d    = new_val & ALIGN_MASK;
        A_SSCRATCH: sscratch_d = new_val;
        A_SEPC:     sepc_d     = new_val & ALIGN_MASK;
        A_SCAUSE:   scause_d   = new_val;
`ifdef CSR_COUNTERS_EN
        A_MCYCLE:   mcycle_d   = new_val;
        A_MINSTRET: minstret_d = new_val;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      priv_q     <= PRIV_M;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mpp_q      <= 2'b00;
      sie_q      <= 1'b0;
      spie_q     <= 1'b0;
      spp_q      <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= '0;
      minstret_q <= '0;
`endif
    end else begin
      priv_q     <= priv_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mpp_q      <= mpp_d;
      sie_q      <= sie_d;
      spie_q     <= spie_d;
      spp_q      <= spp_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      stvec_q    <= stvec_d;
      sscratch_q <= sscratch_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

  assign privilege_mode = priv_q;
  assign trap_vector    = mtvec_q;
  assign mepc_out       = mepc_q;
  assign sepc_out       = sepc_q;

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: CSR access, gating, trap/return flow, priority, reset.
module tb_csr_bank;
  localparam int W = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   csr_addr;
  logic          csr_wr_en;
  logic [1:0]    csr_op;
  logic          csr_imm;
  logic [4:0]    rs1_field;
  logic [W-1:0]  rs1_data;
  logic          trap, mret, sret, retire;
  logic [W-1:0]  trap_cause, trap_pc;
  logic [W-1:0]  rd_data;
  logic          csr_addr_invalid;
  logic [1:0]    privilege_mode;
  logic [W-1:0]  trap_vector, mepc_out, sepc_out;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  csr_bank #(.DATA_SIZE(W)) dut (
    .clock(clock), .reset(reset), .csr_addr(csr_addr), .csr_wr_en(csr_wr_en),
    .csr_op(csr_op), .csr_imm(csr_imm), .rs1_field(rs1_field), .rs1_data(rs1_data),
    .trap(trap), .mret(mret), .sret(sret), .retire(retire),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .rd_data(rd_data),
    .csr_addr_invalid(csr_addr_invalid), .privilege_mode(privilege_mode),
    .trap_vector(trap_vector), .mepc_out(mepc_out), .sepc_out(sepc_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    csr_wr_en = 1'b0; csr_op = 2'b00; csr_imm = 1'b0; rs1_field = 5'd0;
    rs1_data = '0; trap = 1'b0; mret = 1'b0; sret = 1'b0; retire = 1'b0;
    trap_cause = '0; trap_pc = '0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard read: expected value goes through the queue
  task automatic rd(input string tag, input logic [11:0] a, input logic [W-1:0] exp);
    csr_wr_en = 1'b0;
    csr_addr  = a;
    #1;
    exp_q.push_back(exp);
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic drive_csr(input logic [11:0] a, input logic [1:0] op, input logic imm,
                           input logic [4:0] f, input logic [W-1:0] d);
    csr_addr = a; csr_wr_en = 1'b1; csr_op = op; csr_imm = imm;
    rs1_field = f; rs1_data = d;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic imm,
                    input logic [4:0] f, input logic [W-1:0] d);
    drive_csr(a, op, imm, f, d);
    tick();
    idle();
  endtask

  task automatic do_trap(input logic [W-1:0] pc, input logic [W-1:0] cause);
    trap = 1'b1; trap_pc = pc; trap_cause = cause;
    tick();
    idle();
  endtask

  task automatic pulse_mret();
    mret = 1'b1; tick(); idle();
  endtask

  task automatic pulse_sret();
    sret = 1'b1; tick(); idle();
  endtask

  initial begin
    reset = 1'b1;
    csr_addr = 12'h300;
    idle();
    #2;
    chk("reset_priv", W'(privilege_mode), W'(3));
    rd("reset_mstatus", 12'h300, '0);
    rd("reset_misa", 12'h301, 64'h8000_0000_0014_0100);
    chk("reset_tvec", trap_vector, '0);
    chk("reset_mepc", mepc_out, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;

    // CSRRW mscratch: old value visible in the write cycle
    drive_csr(12'h340, 2'b01, 1'b0, 5'd5, 64'h1234);
    #1;
    chk("rw_old", rd_data, '0);
    chk("rw_valid", W'(csr_addr_invalid), '0);
    tick();
    idle();
    rd("rw_new", 12'h340, 64'h1234);

    // set/clear gating
    wr(12'h300, 2'b10, 1'b0, 5'd0, 64'hFFFF);
    rd("rs_x0_nowrite", 12'h300, '0);
    wr(12'h300, 2'b10, 1'b1, 5'd8, '0);
    rd("rsi_mie", 12'h300, 64'h8);
    wr(12'h300, 2'b11, 1'b1, 5'd8, '0);
    rd("rci_mie", 12'h300, 64'h0);

    // mstatus field masking and reserved MPP
    wr(12'h300, 2'b01, 1'b0, 5'd1, 64'h1888);
    rd("mstatus_fields", 12'h300, 64'h1888);
    wr(12'h300, 2'b01, 1'b0, 5'd1, 64'h1000);
    rd("mpp_reserved", 12'h300, 64'h1800);
    wr(12'h300, 2'b01, 1'b0, 5'd1, '1);
    rd("mstatus_ones", 12'h300, 64'h1888);

    // alignment forcing
    wr(12'h305, 2'b01, 1'b0, 5'd1, 64'h8000_0003);
    rd("mtvec_align", 12'h305, 64'h8000_0000);
    chk("trap_vector", trap_vector, 64'h8000_0000);
    wr(12'h141, 2'b01, 1'b0, 5'd1, 64'h1237);
    chk("sepc_align", sepc_out, 64'h1234);
    wr(12'h100, 2'b01, 1'b0, 5'd1, '1);
    rd("sstatus_mask", 12'h100, 64'h122);

    // mret into Supervisor
    wr(12'h300, 2'b01, 1'b0, 5'd1, 64'h0888);
    pulse_mret();
    chk("mret_to_s", W'(privilege_mode), W'(1));
    rd("s_read_mstatus", 12'h300, '0);
    chk("s_mstatus_inval", W'(csr_addr_invalid), W'(1));
    rd("s_read_sstatus", 12'h100, 64'h122);

    // trap from Supervisor with MIE=1
    do_trap(64'h8000_0102, 64'd8);
    chk("trap_priv", W'(privilege_mode), W'(3));
    chk("trap_mepc", mepc_out, 64'h8000_0100);
    rd("trap_mstatus", 12'h300, 64'h880);
    rd("trap_mcause", 12'h342, 64'd8);

    // mret back to S, then again to U (shows MPP cleared to User)
    pulse_mret();
    chk("mret_priv_s", W'(privilege_mode), W'(1));
    pulse_mret();
    chk("mret_priv_u", W'(privilege_mode), W'(0));
    rd("u_read_mstatus", 12'h300, '0);
    chk("u_mstatus_inval", W'(csr_addr_invalid), W'(1));

    do_trap(64'h200, 64'd2);
    chk("trap_u_priv", W'(privilege_mode), W'(3));
    rd("trap_u_mstatus", 12'h300, 64'h080);

    // sret: SPP=1 -> Supervisor, then SPP=0 -> User
    pulse_sret();
    chk("sret_priv_s", W'(privilege_mode), W'(1));
    rd("sret_sstatus", 12'h100, 64'h022);
    pulse_sret();
    chk("sret_priv_u", W'(privilege_mode), W'(0));

    // trap + mret + CSRRW mepc together: trap alone wins
    do_trap(64'h300, 64'd3);
    drive_csr(12'h341, 2'b01, 1'b0, 5'd1, 64'h4444);
    trap = 1'b1; mret = 1'b1; trap_pc = 64'h507; trap_cause = 64'd5;
    tick();
    idle();
    chk("prio_mepc", mepc_out, 64'h504);
    chk("prio_priv", W'(privilege_mode), W'(3));
    rd("prio_mcause", 12'h342, 64'd5);
    rd("prio_mstatus", 12'h300, 64'h1800);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 2'b01, 1'b0, 5'd1, '0);
    drive_csr(12'hC00, 2'b01, 1'b0, 5'd1, 64'hDEAD);
    #1;
    chk("cycle_ro_inval", W'(csr_addr_invalid), W'(1));
    tick();
    idle();
    rd("cycle_unchanged", 12'hC00, 64'd1);
    wr(12'hB00, 2'b01, 1'b0, 5'd1, '1);
    rd("mcycle_ones", 12'hB00, '1);
    tick();
    rd("mcycle_wrap", 12'hB00, '0);
    retire = 1'b1;
    tick(); tick(); tick();
    retire = 1'b0;
    rd("instret_3", 12'hC02, 64'd3);
    rd("minstret_3", 12'hB02, 64'd3);
`else
    rd("no_mcycle", 12'hB00, '0);
    chk("mcycle_inval", W'(csr_addr_invalid), W'(1));
    rd("no_cycle", 12'hC00, '0);
    chk("cycle_inval", W'(csr_addr_invalid), W'(1));
    drive_csr(12'hC00, 2'b01, 1'b0, 5'd1, 64'h5);
    #1;
    chk("cycle_wr_inval", W'(csr_addr_invalid), W'(1));
    idle();
`endif

    // reset mid-operation with a write and a return pending
    wr(12'h340, 2'b01, 1'b0, 5'd1, 64'h55);
    pulse_mret();
    drive_csr(12'h340, 2'b01, 1'b0, 5'd1, 64'h99);
    sret = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_priv", W'(privilege_mode), W'(3));
    chk("rst_tvec", trap_vector, '0);
    chk("rst_mepc", mepc_out, '0);
    chk("rst_sepc", sepc_out, '0);
    idle();
    rd("rst_mscratch", 12'h340, '0);
`ifdef CSR_COUNTERS_EN
    rd("rst_mcycle", 12'hB00, '0);
    rd("rst_minstret", 12'hB02, '0);
`endif
    tick();
    reset = 1'b0;
    rd("rst_hold_mscratch", 12'h340, '0);
    rd("rst_misa", 12'h301, 64'h8000_0000_0014_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 Parameter: DATA_SIZE, default 64, datapath and CSR width (32 or 64).
REQ-002 clock  in  1  rising-edge clock; one clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 csr_addr  in  12  CSR address from instruction[31:20].
REQ-005 csr_wr_en  in  1  CSR instruction in this cycle (write intent further gated by REQ-011).
REQ-006 csr_op  in  2  01 write, 10 set, 11 clear.
REQ-007 csr_imm  in  1  1 selects zero-extended rs1_field as operand, 0 selects rs1_data.
REQ-008 rs1_field  in  5  rs1 index / uimm; rs1_data  in  DATA_SIZE  rs1 value.
REQ-009 trap, mret, sret, retire  in  1 each; trap_cause  in  DATA_SIZE; trap_pc  in  DATA_SIZE.
REQ-010 Outputs:
- rd_data (DATA_SIZE): old CSR value.
- csr_addr_invalid (1).
- privilege_mode (2): User=0, Supervisor=1, Machine=3.
- trap_vector, mepc_out, sepc_out (DATA_SIZE each).

Function
REQ-011 Write occurs iff csr_wr_en=1, csr_addr_invalid=0, and (csr_op=01 or rs1_field≠0).
REQ-012 New value:
- op 01: operand.
- op 10: old|operand.
- op 11: old&~operand.
- Committed on the rising edge.
REQ-013 rd_data is combinational from csr_addr and always shows the pre-write value; invalid addresses read 0.
REQ-014 Implemented CSRs:
- mstatus 0x300, misa 0x301 (writes ignored), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- sstatus 0x100, stvec 0x105, sscratch 0x140, sepc 0x141, scause 0x142.
- mhartid 0xF14 (read-only, 0).
REQ-015 csr_addr_invalid is combinational and asserts when any of the following holds:
- address not implemented;
- privilege_mode < csr_addr[9:8];
- csr_addr[11:10]=11 with write intent per REQ-011.
REQ-016 sstatus is a masked view of mstatus. Only SIE[1], SPIE[5] and SPP[8] are readable or writable through it.
REQ-017 Writable mstatus fields are MIE[3], MPIE[7] and MPP[12:11]. All other mstatus bits read 0. A write of MPP=10 leaves MPP unchanged.
REQ-018 mepc/sepc bits[1:0] and mtvec/stvec bits[1:0] are forced to 0 (direct mode only).
REQ-019 trap_vector equals mtvec; all traps are taken to Machine mode (no delegation).
REQ-020 On a rising edge with trap=1:
- mepc<=trap_pc (REQ-018 masking), mcause<=trap_cause.
- MPP<=privilege_mode, MPIE<=MIE, MIE<=0.
- privilege_mode<=Machine.
REQ-021 mret: privilege_mode<=MPP, MIE<=MPIE, MPIE<=1, MPP<=User.
REQ-022 sret: privilege_mode<=(SPP ? Supervisor : User), SIE<=SPIE, SPIE<=1, SPP<=0.
REQ-023 Priority within one cycle is trap > mret > sret > CSR write. A lower-priority event in the same cycle is dropped entirely.
REQ-024 mepc_out/sepc_out continuously reflect the mepc/sepc registers, so the fetch unit can redirect on mret/sret in the same cycle.

Reset
REQ-025 Reset clears every CSR to 0 except misa, which returns its constant. privilege_mode resets to Machine.
REQ-026 Reset asserted mid-operation overrides any pending write, trap or return in that cycle. Outputs reach reset values without a clock edge.

Configuration
REQ-027 Macro CSR_COUNTERS_EN. When defined, the following DATA_SIZE-bit counters exist:
- mcycle 0xB00: increments every cycle.
- minstret 0xB02: increments when retire=1.
- cycle 0xC00 and instret 0xC02: read-only aliases, readable in all modes.
REQ-028 Counter rules:
- Counters wrap from all-ones to 0.
- A CSR write to a counter in the same cycle wins over its increment.
- Counters reset to 0.
REQ-029 When CSR_COUNTERS_EN is undefined, addresses 0xB00, 0xB02, 0xC00 and 0xC02 are unimplemented and raise csr_addr_invalid per REQ-015.

Verification
REQ-030 CSRRW mscratch: rs1_data=0x1234 -> rd_data=0 that cycle; next-cycle read returns 0x1234.
REQ-031 Set/clear gating:
- CSRRS mstatus with rs1_field=0 -> no write.
- CSRRSI mstatus with uimm=8 -> MIE=1.
- CSRRCI with uimm=8 -> MIE=0.
REQ-032 In User mode, read 0x300 -> csr_addr_invalid=1. Write 0xC00 in Machine mode -> csr_addr_invalid=1, counter unchanged.
REQ-033 Trap/return sequence:
- Supervisor mode, MIE=1, trap with trap_pc=0x8000_0102, cause=8 -> mepc=0x8000_0100, MPP=01, MPIE=1, MIE=0, privilege_mode=Machine.
- mret -> privilege_mode=Supervisor, MIE=1, MPP=00.
REQ-034 trap and mret asserted together with a pending CSRRW to mepc -> only the trap effects are applied.
REQ-035 With CSR_COUNTERS_EN: write mcycle=all-ones -> reads 0 one cycle later. retire held 3 cycles -> minstret=3. Assert reset mid-count -> counters read 0 immediately.
